// File: rtl/nibble_swap_arbiter_pkg.sv
// Shared constants and the nibble transform for nibble_swap_arbiter.
// Imported by the interface, arbiter and top.
package nibble_arb_pkg;

  localparam logic [1:0] MODE_SWAP     = 2'd0;
  localparam logic [1:0] MODE_PASS     = 2'd1;
  localparam logic [1:0] MODE_INV      = 2'd2;
  localparam logic [1:0] MODE_SWAP_INV = 2'd3;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam int unsigned XFORM_MAX_W = 64;

  // Operates on a 64-bit container; w is the live data width.
  function automatic logic [63:0] xform(
    input logic [1:0]  mode,
    input logic [63:0] data,
    input int unsigned w = 8
  );
    logic [63:0] mask;
    logic [63:0] d;
    logic [63:0] sw;
    int unsigned h;
    h    = w / 2;
    mask = (w >= XFORM_MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
    d    = data & mask;
    sw   = ((d >> h) | (d << h)) & mask;
    case (mode)
      MODE_SWAP: xform = sw;
      MODE_PASS: xform = d;
      MODE_INV:  xform = ~d & mask;
      default:   xform = ~sw & mask;
    endcase
  endfunction

endpackage

// File: rtl/nibble_swap_arbiter_if.sv
// Requester/result handshake bundle for nibble_swap_arbiter.
// slave = arbiter side, master = requesters plus consumer.
interface nibble_swap_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 1
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [1:0]                cfg_mode;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic [ID_W-1:0]           out_id;
  logic                      out_ready;
  logic [7:0]                txn_count;

  modport slave (
    input  req_valid,
    input  req_data,
    input  cfg_mode,
    input  out_ready,
    output req_ready,
    output out_valid,
    output out_data,
    output out_id,
    output txn_count
  );

  modport master (
    output req_valid,
    output req_data,
    output cfg_mode,
    output out_ready,
    input  req_ready,
    input  out_valid,
    input  out_data,
    input  out_id,
    input  txn_count
  );
endinterface

// File: rtl/nibble_swap_arbiter_rr.sv
// Combinational round-robin picker.
// Search starts one past the previous winner and wraps.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  always_comb begin
    int   idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/nibble_swap_arbiter.sv
// Shares one nibble transform between NUM_REQ requesters.
// One-entry output register; counts accepted requests.
module nibble_swap_arbiter
  import nibble_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 1
) (
  input logic                 clk,
  input logic                 rst,
  nibble_swap_arbiter_if.slave bus
);

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [7:0]        cnt_q, cnt_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gidx;
  logic               space;
  logic               accept;
  logic [DATA_W-1:0]  sel_data;
  logic [63:0]        xf;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (bus.req_valid),
    .last      (last_q),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign space  = (state_q == ST_EMPTY) | bus.out_ready;
  assign bus.req_ready = grant & {NUM_REQ{space & ~rst}};
  assign accept = |bus.req_ready;

  assign sel_data = bus.req_data[gidx*DATA_W +: DATA_W];
  assign xf = xform(bus.cfg_mode, 64'(sel_data), DATA_W);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      accept: begin
        state_d = ST_FULL;
        data_d  = xf[DATA_W-1:0];
        id_d    = gidx;
        last_d  = gidx;
        cnt_d   = cnt_q + 8'd1;
      end
      (!accept && state_q == ST_FULL && bus.out_ready): begin
        state_d = ST_EMPTY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      id_q    <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_data  = data_q;
  assign bus.out_id    = id_q;
  assign bus.txn_count = cnt_q;

endmodule

// File: doc/nibble_swap_arbiter.md
# nibble_swap_arbiter

Round-robin controller that shares one nibble-swap transform unit between NUM_REQ requesters over valid/ready handshakes. Each accepted request is transformed according to the configured mode, registered, and presented on a single result port tagged with the requester index. It sits between the TinyTapeout I/O wrapper (`ui_in` / `uio_in` fan-in) and downstream consumers, and also keeps a running count of accepted transactions.

## Interface
- `NUM_REQ`, default 2: number of requesters. Range 2..4.
- `DATA_W`, default 8: data width. Must be even; nibble = DATA_W/2.
- `ID_W`, default 1: requester index width, equal to clog2(NUM_REQ).
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  NUM_REQ: per-requester request valid.
- `req_data`  in  NUM_REQ*DATA_W: request payloads. Requester i occupies bits [i*DATA_W +: DATA_W].
- `req_ready`  out  NUM_REQ: per-requester accept. At most one bit is high in any cycle.
- `cfg_mode`  in  2: transform select. 0 = nibble swap, 1 = pass-through, 2 = bitwise invert, 3 = swap then invert.
- `out_valid`  out  1: result valid.
- `out_data`  out  DATA_W: transformed result.
- `out_id`  out  ID_W: index of the requester that produced the result.
- `out_ready`  in  1: downstream accept.
- `txn_count`  out  8: number of accepted requests, modulo 256.

## Operation
- Transfer rules:
  - A request transfers when `req_valid[i] & req_ready[i]`.
  - A result transfers when `out_valid & out_ready`.
  - Requesters hold `req_valid` and `req_data` stable until ready. The block does not check this.
- Space: `space = ~out_valid | out_ready`.
- Grant: combinational round-robin over `req_valid`, starting the search at `last_grant+1` and wrapping at NUM_REQ. `req_ready[i] = grant[i] & space & ~rst`.
- On accept:
  - `out_data <= f(cfg_mode, req_data[i])`
  - `out_id <= i`
  - `out_valid <= 1`
  - `last_grant <= i`
  - `txn_count <= txn_count + 1`, wrapping 255 -> 0.
- `cfg_mode` is sampled in the accept cycle only. Changing it does not alter a held result.
- Nibble swap: `{d[DATA_W/2-1:0], d[DATA_W-1:DATA_W/2]}`.
- FSM has two states:
  - EMPTY (`out_valid=0`): goes to FULL on accept.
  - FULL (`out_valid=1`):
    - `out_ready` and no accept -> EMPTY.
    - `out_ready` and accept -> stays FULL with the new data (back-to-back).
    - `~out_ready` -> stays FULL. Outputs are frozen and all `req_ready` are 0.
- A lone active requester is granted every cycle regardless of `last_grant`.
- With no `req_valid` set, `last_grant` is unchanged.

## Timing
- Reset values:
  - `out_valid=0`, `out_data=0`, `out_id=0`, `txn_count=0`.
  - `last_grant=NUM_REQ-1`, so requester 0 wins first.
  - `req_ready` is all zero.
- Reset asserted mid-operation: the held result is dropped on the next edge, and no request is accepted in any cycle where `rst=1`.
- Latency: 1 cycle. A request accepted at edge N appears on `out_*` after edge N.
- Throughput: 1 result per cycle while `out_ready=1`.
- Fairness: with all requesters continuously valid and `out_ready=1`, grants rotate 0,1,…,NUM_REQ-1. No requester waits more than NUM_REQ-1 accepts.
- `req_ready` depends combinationally on `req_valid`, `out_valid`, `out_ready` and `rst`. `out_*` and `txn_count` are registered only.

## Structure
- Package `nibble_arb_pkg`:
  - mode constants `MODE_SWAP=0`, `MODE_PASS=1`, `MODE_INV=2`, `MODE_SWAP_INV=3`;
  - state constants `ST_EMPTY`, `ST_FULL`;
  - function `xform(mode, data)`.
- Sub-module `rr_arbiter`: parameter NUM_REQ. Inputs `req`, `last`. Outputs one-hot `grant` and encoded `grant_idx`. Purely combinational.
- Top-level TinyTapeout integration (pin mapping) is outside this block.

## Test plan
- Reset, then `req_valid=2'b01`, `req_data[7:0]=8'hA5`, mode 0 -> `req_ready=01` in that cycle. Next cycle `out_valid=1`, `out_data=8'h5A`, `out_id=0`, `txn_count=1`.
- Both requesters valid (`8'h12`, `8'h34`), `out_ready=1` held, mode 0:
  - outputs alternate `8'h21` with id 0, then `8'h43` with id 1, repeating;
  - `req_ready` never has 2 bits set.
- Backpressure: result held with `out_ready=0` for 5 cycles while requests pend -> `out_data` and `out_id` stable and `req_ready=0` throughout. Raising `out_ready` gives a back-to-back handoff with no bubble.
- Modes on `8'h3C`: 0 -> `8'hC3`, 1 -> `8'h3C`, 2 -> `8'hC3`, 3 -> `8'h3C`. Also check `8'h1F`: 2 -> `8'hE0`, 3 -> `8'h0E`.
- 256 accepts -> `txn_count` wraps to 0.
- `rst` pulsed while FULL -> `out_valid=0` on the next edge, no accept during `rst`, requester 0 is granted first afterwards.
